// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state type and bubble NOP fields for pipe_ctrl
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] func;
        logic       wrReg;
    } nop_fields_t;

    localparam nop_fields_t NOP = '{op: 4'h0, func: 4'h0, wrReg: 1'b0};

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// rtl/pipe_ctrl_hazard_unit.sv - load-use hazard detection between ID and EX
module hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = 4
) (
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rs,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rt,
    input  logic                           id_use_rs,
    input  logic                           id_use_rt,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd,
    input  logic                           ex_wrReg,
    input  logic                           ex_isLoad,
    output logic                           loaduse
);

    logic w_rs_hit;
    logic w_rt_hit;

    // Index 0 is compared like any other register.
    assign w_rs_hit = id_use_rs & (id_rs == ex_rd);
    assign w_rt_hit = id_use_rt & (id_rt == ex_rd);
    assign loaduse  = ex_isLoad & (ex_wrReg != NOP.wrReg) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline enable/bubble sequencer with memory watchdog; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int MEM_TIMEOUT         = 255,
    parameter int CNT_BITS            = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rs,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] id_rt,
    input  logic                           id_use_rs,
    input  logic                           id_use_rt,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd,
    input  logic                           ex_wrReg,
    input  logic                           ex_isLoad,
    input  logic                           ex_mispred,
    input  logic                           mem_req,
    input  logic                           mem_ack,
    output logic                           pc_wrt_en,
    output logic                           fd_wrt_en,
    output logic                           de_wrt_en,
    output logic                           em_wrt_en,
    output logic                           mw_wrt_en,
    output logic                           fd_bubble,
    output logic                           de_bubble,
    output logic                           mw_bubble,
    output logic                           mem_err,
    output logic [CNT_BITS-1:0]            stall_cycles,
    output logic [CNT_BITS-1:0]            flush_count
);

    localparam int                   WAIT_BITS = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_BITS-1:0] WAIT_MAX  = WAIT_BITS'(MEM_TIMEOUT);

    state_t               r_state;
    logic [WAIT_BITS-1:0] r_wait_cnt;
    logic                 r_mem_err;
    logic [WAIT_BITS-1:0] w_wait_next;
    logic                 w_loaduse;
    logic                 w_memstall;
    logic                 w_freeze;

    hazard_unit #(
        .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH)
    ) u_hazard (
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt),
        .ex_rd    (ex_rd),
        .ex_wrReg (ex_wrReg),
        .ex_isLoad(ex_isLoad),
        .loaduse  (w_loaduse)
    );

    assign w_memstall  = mem_req & ~mem_ack;
    // In MEM_WAIT the ack alone releases the freeze; mem_req is not re-examined.
    assign w_freeze    = (r_state == MEM_WAIT) ? ~mem_ack : w_memstall;
    assign w_wait_next = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;

    always_comb begin
        pc_wrt_en = 1'b0;
        fd_wrt_en = 1'b0;
        de_wrt_en = 1'b0;
        em_wrt_en = 1'b0;
        mw_wrt_en = 1'b0;
        fd_bubble = 1'b0;
        de_bubble = 1'b0;
        mw_bubble = 1'b0;
        if (!reset) begin
            if (w_freeze) begin
                mw_wrt_en = 1'b1;
                mw_bubble = 1'b1;
            end else if (ex_mispred) begin
                {pc_wrt_en, fd_wrt_en, de_wrt_en, em_wrt_en, mw_wrt_en} = 5'b11111;
                fd_bubble = 1'b1;
                de_bubble = 1'b1;
            end else if (w_loaduse) begin
                {de_wrt_en, em_wrt_en, mw_wrt_en} = 3'b111;
                de_bubble = 1'b1;
            end else begin
                {pc_wrt_en, fd_wrt_en, de_wrt_en, em_wrt_en, mw_wrt_en} = 5'b11111;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else if (r_state == RUN) begin
            if (w_memstall) begin
                r_state    <= MEM_WAIT;
                r_wait_cnt <= '0;
            end
        end else if (mem_ack) begin
            r_state <= RUN;
        end else begin
            r_wait_cnt <= w_wait_next;
            if (w_wait_next == WAIT_MAX) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_BITS-1:0] r_stall_cycles;
    logic [CNT_BITS-1:0] r_flush_count;
    logic                w_flush;

    assign w_flush = ~w_freeze & ex_mispred;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_wrt_en && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage 32-bit core. Every cycle it generates the write enables and bubble-insert strobes for the PC register and the FD, DE, EM and MW pipeline registers. It resolves three conditions in priority order: multi-cycle memory stalls, EX-stage branch mispredicts and load-use hazards. It also runs a memory-wait watchdog.

## Interface
Parameters:
- REG_INDEX_BIT_WIDTH, 4, register-index width.
- MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_err sets (≥1).
- CNT_BITS, 32, performance counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- id_rs, id_rt  in  REG_INDEX_BIT_WIDTH  source indices of the ID instruction.
- id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt.
- ex_rd  in  REG_INDEX_BIT_WIDTH  EX destination index.
- ex_wrReg  in  1  EX instruction writes a register.
- ex_isLoad  in  1  EX instruction is a load.
- ex_mispred  in  1  branch or jump resolved wrong in EX; PC mux takes the target.
- mem_req  in  1  ME instruction accesses data memory.
- mem_ack  in  1  memory access completes this cycle.
- pc_wrt_en, fd_wrt_en, de_wrt_en, em_wrt_en, mw_wrt_en  out  1  register write enables.
- fd_bubble, de_bubble, mw_bubble  out  1  the register loads a NOP (op, func, wrReg = 0) instead of its input at the next edge; meaningful only with its wrt_en = 1.
- mem_err  out  1  sticky watchdog flag.
- stall_cycles, flush_count  out  CNT_BITS  performance counters.

## Operation
Two states: RUN and MEM_WAIT. Derived terms:
- memstall = mem_req & ~mem_ack.
- loaduse = ex_isLoad & ex_wrReg & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- Every index is compared, including index 0; there is no hardwired-zero exemption.

RUN priority, first match wins:
- memstall: pc/fd/de/em enables = 0; mw_wrt_en = 1 with mw_bubble = 1. Next state is MEM_WAIT.
- ex_mispred: all enables = 1; fd_bubble = de_bubble = 1. loaduse is ignored because the ID instruction is squashed.
- loaduse: pc_wrt_en = fd_wrt_en = 0; de_wrt_en = 1 with de_bubble = 1; em and mw enables = 1.
- Otherwise: all enables = 1, no bubbles.

MEM_WAIT:
- While mem_ack = 0, outputs are identical to the RUN memstall case.
- In the cycle mem_ack = 1, outputs equal the RUN evaluation with memstall forced false, so a mispredict or load-use held in frozen EX/ID takes effect in that cycle. Next state is RUN.
- A wait counter clears on MEM_WAIT entry and saturates at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, mem_err sets and holds until reset. The controller keeps waiting.

## Timing
- State, wait counter, mem_err and perf counters are registered. All enable and bubble outputs are combinational from state plus same-cycle inputs, with zero-cycle latency.
- A load-use stall costs exactly 1 cycle. A mispredict costs 2 bubbles. A memory access acked in its first ME cycle costs 0 cycles; one acked N cycles later costs N cycles.
- While reset = 1:
  - state = RUN, wait counter = 0, mem_err = 0, counters = 0.
  - All wrt_en outputs are forced to 0 and all bubbles to 0.
- Reset asserted mid-MEM_WAIT aborts the wait immediately; there is no pending-ack memory.
- mem_ack without mem_req is ignored in RUN.

## Configuration
PIPE_CTRL_PERF_EN:
- Defined:
  - stall_cycles increments each cycle with pc_wrt_en = 0 and reset = 0.
  - flush_count increments each cycle the mispredict branch is taken, in RUN or on the MEM_WAIT ack cycle.
  - Both counters saturate at all-ones.
- Undefined: both ports remain present and are tied to 0; no counter flops are built.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state typedef (RUN = 1'b0, MEM_WAIT = 1'b1);
  - the NOP field constants used for bubbles (op = 4'h0, func = 4'h0, wrReg = 0).
- One sub-module, hazard_unit: combinational loaduse detection from the id_* and ex_* inputs.
- Flops reuse the existing Register module where practical.

## Test plan
- Load-use: ex_isLoad = 1, ex_wrReg = 1, ex_rd = 5, id_use_rs = 1, id_rs = 5 → for one cycle pc/fd enables = 0, de_bubble = 1. With id_rs = 6 → no stall.
- Mispredict colliding with load-use: ex_mispred = 1 and loaduse true → all enables = 1, fd_bubble = de_bubble = 1, flush_count +1.
- Memory wait: mem_req = 1, mem_ack low for 3 cycles then high → 3 cycles of freeze with mw_bubble = 1, release on the ack cycle, stall_cycles = 3.
- Ack-cycle mispredict: ex_mispred = 1 held throughout MEM_WAIT → no bubbles during the wait; fd/de bubbles exactly on the ack cycle.
- Watchdog: MEM_TIMEOUT = 4, mem_ack held 0 → mem_err rises after 4 MEM_WAIT cycles and stays high after ack. Only reset clears it.
- Async reset asserted mid-MEM_WAIT (not on a clock edge) → all enables 0 immediately. After release: state RUN, counters 0.
